// File: rtl/mul_share_if.sv
// rtl/mul_share_if.sv - request/response bus between HIR call sites and the shared multiplier
//
// Purpose: bundles the per-requester handshake, operand and result signals.
//   master : requester side (drives req_valid, req_a, req_b, req_mask)
//   slave  : arbiter side   (drives req_ready, resp_valid, resp_data, inflight, busy)
// Signals:
//   req_valid  [NUM_REQ]     per-requester request strobe
//   req_a/b    [NUM_REQ*32]  operands, requester i in bits [32*i+31:32*i]
//   req_mask   [NUM_REQ]     requester enable; 0 = never granted
//   req_ready  [NUM_REQ]     one-hot grant or zero
//   resp_valid [NUM_REQ]     one-hot result owner strobe
//   resp_data  [32]          product, shared by all requesters
//   inflight   [4]           products currently in the pipeline
//   busy                     inflight != 0
interface mul_share_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_mask;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_data;
    logic [3:0]            inflight;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_mask,
        input  req_ready, resp_valid, resp_data, inflight, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mask,
        output req_ready, resp_valid, resp_data, inflight, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one pipelined 32-bit multiplier
//
// Purpose: grants at most one requester per cycle (round-robin from a rotating
//   pointer), multiplies its operands in a LATENCY-deep pipeline and returns the
//   low 32 bits of the product to the originating requester LATENCY cycles later.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : mul_share_if.slave (requests, grants, responses, occupancy)
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 3
) (
    input  logic          clk,
    input  logic          rst,
    mul_share_if.slave    bus
);

    // Arbitration
    logic [TAG_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_shift;
    logic [TAG_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_gidx;
    logic [TAG_W-1:0]   w_ptr_nxt;
    logic               w_found;
    logic [31:0]        w_a;
    logic [31:0]        w_b;

    // Pipeline: r_vld[1] is the operand stage, r_vld[2..LATENCY] carry products
    logic [LATENCY:1]   r_vld;
    logic [31:0]        r_a1;
    logic [31:0]        r_b1;
    logic [TAG_W-1:0]   r_tag1;
    logic [31:0]        r_prod [2:LATENCY];
    logic [TAG_W-1:0]   r_tag  [2:LATENCY];
    logic [3:0]         w_cnt;

    // Reset forces the eligible set empty so req_ready is zero while rst is low.
    assign w_elig = bus.req_valid & bus.req_mask & {NUM_REQ{rst}};

    // Search pointer, pointer+1, ... with wrap; first eligible index wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        w_shift = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx   = TAG_W'((int'(r_ptr) + k) % NUM_REQ);
            w_shift = w_elig >> w_idx;
            if (!w_found && w_shift[0]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_gidx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
    assign w_a       = 32'(bus.req_a >> (32 * int'(w_gidx)));
    assign w_b       = 32'(bus.req_b >> (32 * int'(w_gidx)));

    assign bus.req_ready = w_found ? (NUM_REQ'(1) << w_gidx) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
            r_vld <= '0;
            // Product registers are cleared so resp_data reads 0 after reset.
            for (int k = 2; k <= LATENCY; k++) begin
                r_prod[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else begin
            r_vld[1] <= w_found;
            if (w_found) begin
                r_a1   <= w_a;
                r_b1   <= w_b;
                r_tag1 <= w_gidx;
                r_ptr  <= w_ptr_nxt;
            end

            r_vld[2] <= r_vld[1];
            if (r_vld[1]) begin
                r_prod[2] <= r_a1 * r_b1;
                r_tag[2]  <= r_tag1;
            end

            // Data only moves with a valid entry, so the last stage (and hence
            // resp_data) keeps its previous product on idle cycles.
            for (int k = 3; k <= LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_prod[k] <= r_prod[k-1];
                    r_tag[k]  <= r_tag[k-1];
                end
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int k = 1; k <= LATENCY; k++) begin
            w_cnt = w_cnt + 4'(r_vld[k]);
        end
    end

    // Gated by rst so a result due in the reset cycle is discarded, not reported.
    assign bus.resp_valid = (r_vld[LATENCY] && rst) ? (NUM_REQ'(1) << r_tag[LATENCY]) : '0;
    assign bus.resp_data  = r_prod[LATENCY];
    assign bus.inflight   = w_cnt;
    assign bus.busy       = (w_cnt != 4'd0);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard testbench for mul_share_arbiter
module tb_mul_share_arbiter;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int TW = 3;

    typedef struct {
        int          acc;
        int          due;
        int          tag;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mul_share_if #(.NUM_REQ(N)) bus ();

    mul_share_arbiter #(.NUM_REQ(N), .LATENCY(L), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          flush_cyc = 0;
    int          ptr       = 0;
    int          last_g    = -1;
    logic        prev_rst  = 1'b0;
    logic        monitor_on = 1'b0;
    exp_t        q[$];

    logic [31:0]  a_op [N];
    logic [31:0]  b_op [N];
    logic [N-1:0] v_in;
    logic [N-1:0] m_in;
    logic         rst_in;
    logic [N-1:0] pending;

    initial begin
        bus.req_valid = '0;
        bus.req_mask  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
    end

    // Apply one cycle of stimulus, then predict the grant and enqueue the result.
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [31:0]  p;
        int g;
        @(posedge clk);
        #1;
        rst           = rst_in;
        bus.req_valid = v_in;
        bus.req_mask  = m_in;
        for (int i = 0; i < N; i++) begin
            bus.req_a[32*i +: 32] = a_op[i];
            bus.req_b[32*i +: 32] = b_op[i];
        end
        #1;
        g = -1;
        if (rst_in) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (g < 0 && v_in[idx] && m_in[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        n_tests++;
        if (bus.req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy);
        end
        last_g = g;
        if (!rst_in) begin
            q.delete();
            ptr = 0;
            if (prev_rst) flush_cyc = cyc;
        end else if (g >= 0) begin
            p = a_op[g] * b_op[g];
            q.push_back('{acc: cyc, due: cyc + L, tag: g, data: p});
            ptr = (g + 1) % N;
        end
        prev_rst = rst_in;
    endtask

    task automatic idle(input int n);
        v_in = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: occupancy and responses checked against the scoreboard queue.
    always @(negedge clk) begin
        if (monitor_on && cyc >= 1) begin
            int exp_inf;
            exp_inf = 0;
            foreach (q[i]) if (q[i].acc < cyc) exp_inf++;
            if (cyc != flush_cyc) begin
                n_tests++;
                if (bus.inflight !== 4'(exp_inf) || bus.busy !== (exp_inf != 0)) begin
                    n_fail++;
                    $display("FAIL inflight cyc=%0d got=%0d/%b exp=%0d", cyc, bus.inflight, bus.busy, exp_inf);
                end
            end
            n_tests++;
            if (bus.resp_valid !== '0) begin
                if (q.size() == 0 || q[0].due != cyc) begin
                    n_fail++;
                    $display("FAIL spurious_resp cyc=%0d got=%b exp=0000", cyc, bus.resp_valid);
                end else begin
                    logic [N-1:0] oh;
                    oh = '0;
                    oh[q[0].tag] = 1'b1;
                    if (bus.resp_valid !== oh || bus.resp_data !== q[0].data) begin
                        n_fail++;
                        $display("FAIL resp cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.resp_valid,
                                 bus.resp_data, oh, q[0].data);
                    end
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && q[0].due == cyc) begin
                n_fail++;
                $display("FAIL missing_resp cyc=%0d got=0000 exp_tag=%0d", cyc, q[0].tag);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            a_op[i] = 32'(i + 1);
            b_op[i] = 32'd10;
        end
        pending = '0;
        rst_in  = 1'b0;
        v_in    = '1;
        m_in    = '1;
        monitor_on = 1'b1;

        // Reset held two cycles with all requesters valid
        step();
        step();

        // Release: first grant to 0, then rotation with a=i+1, b=10
        rst_in = 1'b1;
        for (int i = 0; i < 8; i++) step();
        idle(4);

        // Single request from requester 2: 7*6
        a_op[2] = 32'd7;
        b_op[2] = 32'd6;
        v_in    = 4'b0100;
        step();
        idle(1);

        // Pointer now 3: index 3 masked, wrap to 0, negative operand
        a_op[0] = 32'hFFFF_FFFD;
        b_op[0] = 32'd5;
        v_in    = 4'b1011;
        m_in    = 4'b0111;
        step();
        m_in    = '1;

        // Overflow cases on requester 1
        a_op[1] = 32'h0001_0000;
        b_op[1] = 32'h0001_0000;
        v_in    = 4'b0010;
        step();
        a_op[1] = 32'hFFFF_FFFF;
        b_op[1] = 32'hFFFF_FFFF;
        step();
        idle(4);

        // Mid-operation reset: three accepted, then flushed
        a_op[0] = 32'd3;
        b_op[0] = 32'd9;
        v_in    = 4'b0001;
        step();
        step();
        step();
        rst_in = 1'b0;
        v_in   = '0;
        step();
        rst_in = 1'b1;
        idle(5);

        // Randomized traffic; requesters hold operands until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
                    pending[i] = 1'b1;
                    if ($urandom_range(0, 3) == 0) begin
                        a_op[i] = $urandom_range(0, 100);
                        b_op[i] = $urandom_range(0, 100);
                    end else begin
                        a_op[i] = $urandom;
                        b_op[i] = $urandom;
                    end
                end
            end
            v_in   = pending;
            m_in   = N'($urandom | $urandom);
            rst_in = ($urandom_range(0, 59) != 0);
            step();
            if (last_g >= 0) pending[last_g] = 1'b0;
        end

        rst_in = 1'b1;
        idle(L + 3);

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end

        monitor_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined 32-bit integer multiplier among NUM_REQ requesters, so that independent HIR-generated function instances can use a single DSP resource.
- Each cycle, a round-robin arbiter grants at most one requester. The granted operands enter an internal multiplier pipeline together with a requester tag.
- Each result is returned to its originating requester exactly LATENCY cycles after acceptance.
- Sits between HIR call sites and the multiplier datapath and replaces per-site multiplier instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 3, cycles from request acceptance to result valid (≥2; the multiply stage is registered).
- TAG_W, 3, width of the internal requester tag; must satisfy 2^TAG_W ≥ NUM_REQ.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset; clears state on the clk edge where rst==0.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_a  input  NUM_REQ*32  operand A; requester i occupies bits [32*i+31:32*i].
- req_b  input  NUM_REQ*32  operand B, same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant (or all zero); combinational from req_valid, req_mask and the pointer.
- req_mask  input  NUM_REQ  configuration; a requester whose bit is 0 is never granted.
- resp_valid  output  NUM_REQ  one-hot strobe marking the result owner.
- resp_data  output  32  product (shared bus), meaningful only when resp_valid != 0.
- inflight  output  4  number of products in the pipeline (0..LATENCY).
- busy  output  1  high when inflight != 0.

Behaviour:
- Reset (rst==0 at an edge):
  - pointer ← 0; all pipeline valid bits cleared.
  - resp_valid=0, resp_data=0, inflight=0, busy=0 from the following cycle.
  - req_ready=0 whenever rst==0, regardless of req_valid.
  - Any in-flight products are discarded and never reported. Operand registers need not be cleared.
- Arbitration:
  - Eligible set E = req_valid & req_mask.
  - Grant the first index in E searching pointer, pointer+1, …, NUM_REQ-1, 0, … (wrap-around).
  - A request is accepted in a cycle where req_valid[i] && req_ready[i]. The requester holds its operands stable until accepted.
  - After a grant to index g, pointer ← (g+1) mod NUM_REQ. With no grant, the pointer is unchanged.
  - No backpressure: the pipeline accepts one request every cycle, so an eligible set always produces a grant.
- Datapath:
  - Stage 1 registers a, b, the tag g and valid.
  - Stage 2 registers the low 32 bits of a*b. The low 32 bits are identical for signed and unsigned operands.
  - Stages 3..LATENCY are delay registers carrying product, tag and valid.
  - With acceptance at edge T, resp_valid[g]=1 and resp_data=product during the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles later.
  - resp_valid is a single-cycle pulse per accepted request. The consumer must capture it; there is no hold.
  - When no result is valid, resp_data holds its last value.
- inflight:
  - Equals the popcount of pipeline valid bits.
  - Simultaneous accept and retire leave it unchanged.
- req_mask:
  - May change at any cycle and affects arbitration in the same cycle.
  - Masking does not cancel in-flight work of that requester.
- Mid-operation reset follows the Reset rules above: pipeline flushed, no stale resp_valid afterwards.

Test Plan:
- Reset held low for 2 cycles with all req_valid=1 → req_ready=0000, resp_valid=0000, inflight=0 throughout. After release, the first grant goes to index 0.
- Single request: requester 2 issues a=7, b=6 at cycle 10 → req_ready=0100 at cycle 10; resp_valid=0100 and resp_data=42 at cycle 13 (LATENCY=3); inflight=1 during cycles 11–13.
- Four requesters continuously valid with a=i+1, b=10:
  - Grants rotate 0,1,2,3,0 on consecutive cycles.
  - Results 10, 20, 30, 40 appear back-to-back with the matching one-hot resp_valid.
  - inflight saturates at 3.
- Wrap and mask: pointer=3, req_valid=1011, req_mask=0111 → grant index 0 (index 3 is masked), next pointer=1. Negative operands a=-3 (0xFFFFFFFD), b=5 → resp_data=0xFFFFFFF1.
- Overflow: a=0x00010000, b=0x00010000 → resp_data=0x00000000. a=0xFFFFFFFF, b=0xFFFFFFFF → resp_data=0x00000001.
- Mid-operation reset: three requests accepted at cycles 20–22, rst=0 at cycle 23 → no resp_valid at cycles 23–25; inflight=0 from cycle 24.
